// File: rtl/tsmp_cfg_initiator.sv
// TSMP configuration-bus initiator.
// Turns upstream burst read/write requests into single-word transfers on the
// 19-bit address / 32-bit data configuration bus. Only one read is
// outstanding at a time, and each read word has its own timeout.
module tsmp_cfg_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // upstream request
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rd,
  input  logic [18:0] iv_req_addr,
  input  logic        i_req_addr_fixed,
  input  logic [8:0]  iv_req_len,
  // upstream write data
  input  logic        i_wdata_valid,
  input  logic [31:0] iv_wdata,
  output logic        o_wdata_ready,
  // upstream read data
  output logic        o_rdata_valid,
  output logic [31:0] ov_rdata,
  output logic [18:0] ov_rdata_addr,
  // configuration bus
  output logic [18:0] ov_addr,
  output logic [31:0] ov_wdata,
  output logic        o_addr_fixed,
  output logic        o_wr,
  output logic        o_rd,
  // responder read-back
  input  logic        i_wr,
  input  logic [18:0] iv_addr,
  input  logic        i_addr_fixed,
  input  logic [31:0] iv_rdata,
  // burst status
  output logic        o_done,
  output logic        o_timeout
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [18:0] cur_addr, cur_nx;
  logic [8:0]  remaining, rem_nx;
  logic        fixed, fixed_nx;
  logic [15:0] tmo_cnt, tmo_nx;
  // One-cycle pause in RD_WAIT after a match or timeout, so the upstream
  // strobe goes out before the next o_rd / o_done.
  logic        hold, hold_nx;

  logic        wr_nx, rd_nx, afix_nx, rv_nx, to_nx, done_nx, rrdy_nx, wrdy_nx;
  logic [18:0] addr_nx, raddr_nx;
  logic [31:0] wdata_nx, rdata_nx;

  // The responder's fixed flag carries no information we need for matching.
  logic unused_resp_fixed;
  assign unused_resp_fixed = i_addr_fixed;

  function automatic logic [18:0] adv(input logic [18:0] a, input logic fx);
    return fx ? a : a + 19'd1;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nx = state;
    cur_nx   = cur_addr;
    rem_nx   = remaining;
    fixed_nx = fixed;
    tmo_nx   = tmo_cnt;
    hold_nx  = hold;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    rv_nx    = 1'b0;
    to_nx    = 1'b0;
    addr_nx  = ov_addr;
    wdata_nx = ov_wdata;
    rdata_nx = ov_rdata;
    raddr_nx = ov_rdata_addr;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          cur_nx   = iv_req_addr;
          rem_nx   = iv_req_len;
          fixed_nx = i_req_addr_fixed;
          if (iv_req_len == 9'd0) state_nx = DONE;
          else if (i_req_rd)      state_nx = RD_ISSUE;
          else                    state_nx = WRITE;
        end
      end
      WRITE: begin
        if (remaining == 9'd0) begin
          state_nx = DONE;
        end else if (i_wdata_valid && o_wdata_ready) begin
          wr_nx    = 1'b1;
          addr_nx  = cur_addr;
          wdata_nx = iv_wdata;
          cur_nx   = adv(cur_addr, fixed);
          rem_nx   = remaining - 9'd1;
        end
      end
      RD_ISSUE: begin
        state_nx = RD_WAIT;
        hold_nx  = 1'b0;
        tmo_nx   = tmo_cnt + 16'd1;
      end
      RD_WAIT: begin
        if (hold) begin
          hold_nx  = 1'b0;
          state_nx = (remaining == 9'd0) ? DONE : RD_ISSUE;
        end else if (i_wr && iv_addr == cur_addr) begin
          // a match wins over a timeout firing in the same cycle
          rv_nx    = 1'b1;
          rdata_nx = iv_rdata;
          raddr_nx = cur_addr;
          cur_nx   = adv(cur_addr, fixed);
          rem_nx   = remaining - 9'd1;
          hold_nx  = 1'b1;
        end else if (tmo_cnt >= TMO_LAST) begin
          to_nx   = 1'b1;
          rem_nx  = 9'd0;
          hold_nx = 1'b1;
        end else begin
          tmo_nx = tmo_cnt + 16'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // o_rd is issued on every entry into RD_ISSUE; the timeout restarts there.
    if (state_nx == RD_ISSUE) begin
      rd_nx   = 1'b1;
      addr_nx = cur_nx;
      tmo_nx  = 16'd0;
    end
    afix_nx = (wr_nx || rd_nx) ? fixed_nx : 1'b0;
    done_nx = (state_nx == DONE);
    rrdy_nx = (state_nx == IDLE);
    wrdy_nx = (state_nx == WRITE) && (rem_nx != 9'd0);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Burst bookkeeping and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_addr      <= '0;
      remaining     <= '0;
      fixed         <= 1'b0;
      tmo_cnt       <= '0;
      hold          <= 1'b0;
      o_req_ready   <= 1'b1;
      o_wdata_ready <= 1'b0;
      o_rdata_valid <= 1'b0;
      ov_rdata      <= '0;
      ov_rdata_addr <= '0;
      ov_addr       <= '0;
      ov_wdata      <= '0;
      o_addr_fixed  <= 1'b0;
      o_wr          <= 1'b0;
      o_rd          <= 1'b0;
      o_done        <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      cur_addr      <= cur_nx;
      remaining     <= rem_nx;
      fixed         <= fixed_nx;
      tmo_cnt       <= tmo_nx;
      hold          <= hold_nx;
      o_req_ready   <= rrdy_nx;
      o_wdata_ready <= wrdy_nx;
      o_rdata_valid <= rv_nx;
      ov_rdata      <= rdata_nx;
      ov_rdata_addr <= raddr_nx;
      ov_addr       <= addr_nx;
      ov_wdata      <= wdata_nx;
      o_addr_fixed  <= afix_nx;
      o_wr          <= wr_nx;
      o_rd          <= rd_nx;
      o_done        <= done_nx;
      o_timeout     <= to_nx;
    end
  end

endmodule

// File: tb/tb_tsmp_cfg_initiator.sv
// Bench for tsmp_cfg_initiator: directed bursts plus random bursts, checked
// against an event-level model (expected address sequence, data and timing).
module tb_tsmp_cfg_initiator;
  localparam int TMO = 8;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        i_req_valid = 0, i_req_rd = 0, i_req_addr_fixed = 0;
  logic [18:0] iv_req_addr = '0;
  logic [8:0]  iv_req_len = '0;
  logic        i_wdata_valid = 0;
  logic [31:0] iv_wdata = '0;
  logic        i_wr = 0, i_addr_fixed = 0;
  logic [18:0] iv_addr = '0;
  logic [31:0] iv_rdata = '0;
  logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_addr_fixed;
  logic        o_wr, o_rd, o_done, o_timeout;
  logic [31:0] ov_rdata, ov_wdata;
  logic [18:0] ov_rdata_addr, ov_addr;

  tsmp_cfg_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rd(i_req_rd),
    .iv_req_addr(iv_req_addr), .i_req_addr_fixed(i_req_addr_fixed), .iv_req_len(iv_req_len),
    .i_wdata_valid(i_wdata_valid), .iv_wdata(iv_wdata), .o_wdata_ready(o_wdata_ready),
    .o_rdata_valid(o_rdata_valid), .ov_rdata(ov_rdata), .ov_rdata_addr(ov_rdata_addr),
    .ov_addr(ov_addr), .ov_wdata(ov_wdata), .o_addr_fixed(o_addr_fixed),
    .o_wr(o_wr), .o_rd(o_rd),
    .i_wr(i_wr), .iv_addr(iv_addr), .i_addr_fixed(i_addr_fixed), .iv_rdata(iv_rdata),
    .o_done(o_done), .o_timeout(o_timeout)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0, n_fail = 0;

  typedef struct {
    logic [18:0] addr;
    logic [31:0] data;
    logic        fx;
    int          cyc;
  } ev_t;

  ev_t wr_q[$], rd_q[$], rv_q[$];
  int  done_q[$], to_q[$];

  // Event log of every strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_wr)          wr_q.push_back('{ov_addr, ov_wdata, o_addr_fixed, cyc});
    if (o_rd)          rd_q.push_back('{ov_addr, 32'h0, o_addr_fixed, cyc});
    if (o_rdata_valid) rv_q.push_back('{ov_rdata_addr, ov_rdata, 1'b0, cyc});
    if (o_done)        done_q.push_back(cyc);
    if (o_timeout)     to_q.push_back(cyc);
  end

  // Responder behaviour knobs.
  logic        resp_en = 0, resp_mis = 0, use_val = 0;
  int          resp_delay = 2;
  logic [31:0] resp_val = '0;

  function automatic logic [31:0] rdat(input logic [18:0] a);
    return use_val ? resp_val : (({13'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Responder: answers each o_rd after resp_delay cycles; optionally sends a
  // wrong-address strobe first.
  always begin : responder
    logic [18:0] a;
    @(posedge clk); #1;
    if (resp_en && o_rd) begin
      a = ov_addr;
      repeat (resp_delay) @(posedge clk);
      #1;
      if (resp_mis) begin
        i_wr = 1; iv_addr = a + 19'd1; iv_rdata = ~rdat(a);
        @(posedge clk); #1; i_wr = 0;
        @(posedge clk); #1;
      end
      i_wr = 1; iv_addr = a; iv_rdata = rdat(a);
      @(posedge clk); #1; i_wr = 0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] exp_addr(input logic [18:0] a, input logic fx, input int k);
    return fx ? a : a + 19'(k);
  endfunction

  task automatic chk_reset_outputs(input string p);
    chk({p, "_req_ready"}, o_req_ready, 1);
    chk({p, "_wdata_ready"}, o_wdata_ready, 0);
    chk({p, "_strobes"}, {o_wr, o_rd, o_rdata_valid, o_done, o_timeout, o_addr_fixed}, 0);
    chk({p, "_addr"}, {ov_addr, ov_rdata_addr}, 0);
    chk({p, "_data"}, {ov_wdata, ov_rdata}, 0);
  endtask

  // Called #1 after a clock edge with the DUT idle; returns the accept cycle.
  task automatic send_req(input logic rd, input logic [18:0] a, input logic fx,
                          input logic [8:0] len, output int n);
    chk("req_ready_before", o_req_ready, 1);
    i_req_valid = 1; i_req_rd = rd; iv_req_addr = a; i_req_addr_fixed = fx; iv_req_len = len;
    n = cyc;
    @(posedge clk); #1;
    i_req_valid = 0;
  endtask

  task automatic wait_done(input int b);
    int g;
    g = 0;
    while (done_q.size() <= b && g < 400) begin
      @(posedge clk); #1; g++;
    end
    chk("done_seen", done_q.size() > b, 1);
  endtask

  task automatic run_write(input logic [18:0] a, input logic fx, input logic [8:0] len,
                           input bit stall, input bit seq, input logic [31:0] base);
    int n, k, g, bw, br, bd;
    bit acc;
    logic [31:0] wd[$];
    bw = wr_q.size(); br = rd_q.size(); bd = done_q.size();
    for (int j = 0; j < int'(len); j++) wd.push_back(seq ? base + 32'(j) : $urandom);
    send_req(1'b0, a, fx, len, n);
    k = 0; g = 0;
    while (k < int'(len) && g < 2000) begin
      if (stall && $urandom_range(3) == 0) i_wdata_valid = 0;
      else begin i_wdata_valid = 1; iv_wdata = wd[k]; end
      acc = i_wdata_valid && o_wdata_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    i_wdata_valid = 0;
    wait_done(bd);
    chk("wr_count", wr_q.size() - bw, int'(len));
    chk("wr_no_rd", rd_q.size() - br, 0);
    for (int j = 0; j < int'(len) && bw + j < wr_q.size(); j++) begin
      chk($sformatf("wr_addr[%0d]", j), wr_q[bw + j].addr, exp_addr(a, fx, j));
      chk($sformatf("wr_data[%0d]", j), wr_q[bw + j].data, wd[j]);
      chk($sformatf("wr_fixed[%0d]", j), wr_q[bw + j].fx, fx);
      if (!stall) chk($sformatf("wr_cyc[%0d]", j), wr_q[bw + j].cyc, n + 2 + j);
    end
    if (done_q.size() > bd) begin
      if (len == 0) chk("len0_done_cyc", done_q[bd], n + 1);
      else if (wr_q.size() > bw) chk("wr_done_cyc", done_q[bd], wr_q[wr_q.size() - 1].cyc + 1);
    end
    chk("wr_done_once", done_q.size() - bd, 1);
  endtask

  task automatic run_read(input logic [18:0] a, input logic fx, input logic [8:0] len,
                          input int d, input bit mis, input bit no_resp);
    int n, br, bv, bt, bd, bw, lat;
    logic [18:0] ea;
    br = rd_q.size(); bv = rv_q.size(); bt = to_q.size(); bd = done_q.size(); bw = wr_q.size();
    resp_delay = d; resp_mis = mis; resp_en = !no_resp;
    send_req(1'b1, a, fx, len, n);
    wait_done(bd);
    chk("rd_no_wr", wr_q.size() - bw, 0);
    if (len == 0) begin
      chk("len0_rd_count", rd_q.size() - br, 0);
      if (done_q.size() > bd) chk("len0_done_cyc", done_q[bd], n + 1);
    end else if (no_resp) begin
      chk("to_rd_count", rd_q.size() - br, 1);
      chk("to_rv_count", rv_q.size() - bv, 0);
      chk("to_count", to_q.size() - bt, 1);
      if (rd_q.size() > br && to_q.size() > bt && done_q.size() > bd) begin
        chk("to_rd_cyc", rd_q[br].cyc, n + 1);
        chk("to_cyc", to_q[bt], rd_q[br].cyc + TMO);
        chk("to_done_cyc", done_q[bd], to_q[bt] + 1);
      end
    end else begin
      lat = d + (mis ? 2 : 0) + 1;
      chk("rd_count", rd_q.size() - br, int'(len));
      chk("rv_count", rv_q.size() - bv, int'(len));
      chk("rd_no_timeout", to_q.size() - bt, 0);
      for (int k = 0; k < int'(len) && br + k < rd_q.size() && bv + k < rv_q.size(); k++) begin
        ea = exp_addr(a, fx, k);
        chk($sformatf("rd_addr[%0d]", k), rd_q[br + k].addr, ea);
        chk($sformatf("rd_fixed[%0d]", k), rd_q[br + k].fx, fx);
        chk($sformatf("rv_addr[%0d]", k), rv_q[bv + k].addr, ea);
        chk($sformatf("rv_data[%0d]", k), rv_q[bv + k].data, rdat(ea));
        chk($sformatf("rd_cyc[%0d]", k), rd_q[br + k].cyc,
            (k == 0) ? n + 1 : rv_q[bv + k - 1].cyc + 1);
        chk($sformatf("rv_cyc[%0d]", k), rv_q[bv + k].cyc, rd_q[br + k].cyc + lat);
      end
      if (done_q.size() > bd && rv_q.size() > bv)
        chk("rd_done_cyc", done_q[bd], rv_q[rv_q.size() - 1].cyc + 1);
    end
    chk("rd_done_once", done_q.size() - bd, 1);
    resp_en = 0; resp_mis = 0;
  endtask

  initial begin
    int n, k, g, bw, bd;
    bit acc;
    // reset state
    #1 rst_n = 0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset");

    // incrementing write burst, streamed
    run_write(19'h00010, 1'b0, 9'd4, 1'b0, 1'b1, 32'hA0);
    // fixed-address read burst, responder echoes 0x55 after 2 cycles
    use_val = 1; resp_val = 32'h55;
    run_read(19'h00100, 1'b1, 9'd3, 2, 1'b0, 1'b0);
    // address wrap
    run_write(19'h7FFFE, 1'b0, 9'd3, 1'b0, 1'b1, 32'hC0);
    // timeout: no response
    run_read(19'h00300, 1'b0, 9'd2, 2, 1'b0, 1'b1);
    // response on the last cycle before timeout counts as a match
    use_val = 0;
    run_read(19'h00400, 1'b0, 9'd1, TMO - 1, 1'b0, 1'b0);
    // mismatched response followed by the real one
    use_val = 1; resp_val = 32'hDEADBEEF;
    run_read(19'h00020, 1'b0, 9'd1, 2, 1'b1, 1'b0);
    use_val = 0;

    // reset in the middle of a stalled write burst
    bw = wr_q.size(); bd = done_q.size();
    send_req(1'b0, 19'h00200, 1'b0, 9'd8, n);
    k = 0; g = 0;
    while (k < 3 && g < 50) begin
      i_wdata_valid = 1; iv_wdata = 32'hB0 + 32'(k);
      acc = o_wdata_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    i_wdata_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1 chk_reset_outputs("mid_reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_reset_wr_count", wr_q.size() - bw, 3);
    for (int j = 0; j < 3 && bw + j < wr_q.size(); j++)
      chk($sformatf("mid_reset_wr_addr[%0d]", j), wr_q[bw + j].addr, 19'h00200 + 19'(j));
    chk("mid_reset_no_done", done_q.size() - bd, 0);
    chk("mid_reset_idle", o_req_ready, 1);
    // zero-length request after reset
    run_write(19'h00050, 1'b0, 9'd0, 1'b0, 1'b1, 32'h0);

    // random bursts
    for (int it = 0; it < 20; it++) begin
      logic [18:0] ra;
      logic [8:0]  rl;
      logic        rfx;
      ra  = ($urandom_range(3) == 0) ? 19'h7FFF0 + 19'($urandom_range(15)) : 19'($urandom);
      rl  = ($urandom_range(7) == 0) ? 9'd0 : 9'($urandom_range(10, 1));
      rfx = 1'($urandom_range(1));
      if ($urandom_range(1) == 1)
        run_read(ra, rfx, rl, $urandom_range(5, 1), 1'($urandom_range(1)), 1'b0);
      else
        run_write(ra, rfx, rl, 1'($urandom_range(1)), 1'b0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
